// File: rtl/led_pkg.sv
// led_pkg
// Shared types and defaults for the LED matrix scan path.
//   scan_state_t : scan sequencer states
//   DEF_COLS     : columns shifted per sub-field
//   DEF_PLANES   : bit-planes per colour channel
//   DEF_BASE_ON  : lit cycles for plane 0
//   on_time()    : lit cycles for a given plane (base_on << plane)
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLANK,
    LATCH
  } scan_state_t;

  localparam int DEF_COLS    = 32;
  localparam int DEF_PLANES  = 4;
  localparam int DEF_BASE_ON = 64;

  // Binary-coded modulation: each plane is lit twice as long as the one below.
  function automatic int unsigned on_time(input int unsigned plane,
                                          input int unsigned base_on = DEF_BASE_ON);
    return base_on << plane;
  endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// bcm_on_timer
// Down-counter holding the remaining lit time of the displayed sub-field.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : new lit time
//   nonzero  : count != 0, the panel may be lit
//   expiring : count <= 1, the count is 0 from the next cycle on
module bcm_on_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             nonzero,
  output logic             expiring
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign nonzero  = (count != '0);
  // Zero or one both mean the count will read zero on the next cycle,
  // which is when the sequencer wants to be in BLANK.
  assign expiring = (count[WIDTH-1:1] == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl
// Scan sequencer for a 32x16 HUB75-style panel (1/8 scan). Outer loop is
// bit-planes, inner loop is rows; the next sub-field is shifted while the
// current one is displayed.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enb         : run request, scanning continues while high
//   row_eq_7    : row counter's load row is the last row
//   rowct_clr   : clear the row counter (held while idle)
//   rowct_enb   : advance the row counter (latch cycle)
//   col         : column index for the frame-buffer read
//   load_plane  : plane being shifted
//   disp_plane  : plane being displayed
//   sclk, lat   : panel shift clock and latch strobe
//   oe_n        : panel output enable, active-low
//   frame_done  : pulse on the last latch of a frame
module matrix_scan_ctrl
  import led_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int PLANES  = DEF_PLANES,
  parameter int BASE_ON = DEF_BASE_ON
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic                      row_eq_7,
  output logic                      rowct_clr,
  output logic                      rowct_enb,
  output logic [$clog2(COLS)-1:0]   col,
  output logic [$clog2(PLANES)-1:0] load_plane,
  output logic [$clog2(PLANES)-1:0] disp_plane,
  output logic                      sclk,
  output logic                      lat,
  output logic                      oe_n,
  output logic                      frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PLANES);
  localparam int TW = $clog2((BASE_ON << (PLANES - 1)) + 1);

  scan_state_t   state, state_d;
  logic          phase, phase_d;
  logic [CW-1:0] col_d;
  logic [PW-1:0] load_plane_d, disp_plane_d;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_nz, timer_expiring;

  // The new disp_plane is the current load_plane, so the lit time is
  // looked up from load_plane while in LATCH.
  assign timer_val = TW'(on_time(32'(load_plane), BASE_ON));

  bcm_on_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .nonzero  (timer_nz),
    .expiring (timer_expiring)
  );

  // Registered sequencer state; reset aborts any sub-field in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      col        <= '0;
      load_plane <= '0;
      disp_plane <= '0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      col        <= col_d;
      load_plane <= load_plane_d;
      disp_plane <= disp_plane_d;
    end
  end

  // Next-state logic. SHIFT spends two cycles per column (sclk low, then
  // high). Leaving SHIFT or WAIT is decided one cycle early so that BLANK
  // lands on the first cycle with the timer at zero.
  always_comb begin
    state_d      = state;
    phase_d      = phase;
    col_d        = col;
    load_plane_d = load_plane;
    disp_plane_d = disp_plane;
    timer_load   = 1'b0;

    case (state)
      IDLE: begin
        if (enb) begin
          state_d = SHIFT;
          col_d   = '0;
          phase_d = 1'b0;
        end
      end

      SHIFT: begin
        if (!phase) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col == CW'(COLS - 1)) begin
            state_d = timer_expiring ? BLANK : WAIT;
          end else begin
            col_d = col + CW'(1);
          end
        end
      end

      WAIT: begin
        if (timer_expiring) begin
          state_d = BLANK;
        end
      end

      BLANK: begin
        if (enb) begin
          state_d = LATCH;
        end else begin
          state_d      = IDLE;
          load_plane_d = '0;
          disp_plane_d = '0;
        end
      end

      LATCH: begin
        disp_plane_d = load_plane;
        if (row_eq_7) begin
          load_plane_d = (load_plane == PW'(PLANES - 1)) ? '0 : load_plane + PW'(1);
        end
        timer_load = 1'b1;
        state_d    = SHIFT;
        col_d      = '0;
        phase_d    = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Panel strobes decode only registered state, phase and timer.
  assign sclk       = (state == SHIFT) && phase;
  assign lat        = (state == LATCH);
  assign rowct_enb  = (state == LATCH);
  assign rowct_clr  = (state == IDLE);
  assign oe_n       = !(timer_nz && ((state == SHIFT) || (state == WAIT)));
  assign frame_done = (state == LATCH) && row_eq_7 && (load_plane == PW'(PLANES - 1));

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl
// Directed bench for matrix_scan_ctrl. Two instances share the clock:
// u_dut_a with BASE_ON = 64 and u_dut_b with BASE_ON = 8. Each has its own
// row counter model. Expected sub-field results are queued up front and
// popped as each latch arrives.
module tb_matrix_scan_ctrl;

  typedef struct {
    int period;
    int lit;
    int first_lit;
    int last_lit;
    int rises;
    int last_sclk;
    int lp;
    int dp;
    int fd;
    int row;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, enb_a, rst_b, enb_b;
  logic       row_eq_7_a, row_eq_7_b;
  logic       rowct_clr_a, rowct_enb_a, sclk_a, lat_a, oe_n_a, frame_done_a;
  logic       rowct_clr_b, rowct_enb_b, sclk_b, lat_b, oe_n_b, frame_done_b;
  logic [4:0] col_a, col_b;
  logic [1:0] load_plane_a, disp_plane_a, load_plane_b, disp_plane_b;
  logic [2:0] row_a, row_b;

  matrix_scan_ctrl #(.COLS(32), .PLANES(4), .BASE_ON(64)) u_dut_a (
    .clk(clk), .rst(rst_a), .enb(enb_a), .row_eq_7(row_eq_7_a),
    .rowct_clr(rowct_clr_a), .rowct_enb(rowct_enb_a), .col(col_a),
    .load_plane(load_plane_a), .disp_plane(disp_plane_a),
    .sclk(sclk_a), .lat(lat_a), .oe_n(oe_n_a), .frame_done(frame_done_a)
  );

  matrix_scan_ctrl #(.COLS(32), .PLANES(4), .BASE_ON(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .enb(enb_b), .row_eq_7(row_eq_7_b),
    .rowct_clr(rowct_clr_b), .rowct_enb(rowct_enb_b), .col(col_b),
    .load_plane(load_plane_b), .disp_plane(disp_plane_b),
    .sclk(sclk_b), .lat(lat_b), .oe_n(oe_n_b), .frame_done(frame_done_b)
  );

  // Row counter models, one per instance.
  always_ff @(posedge clk) begin
    if (rst_a || rowct_clr_a) row_a <= 3'd0;
    else if (rowct_enb_a)     row_a <= row_a + 3'd1;
    if (rst_b || rowct_clr_b) row_b <= 3'd0;
    else if (rowct_enb_b)     row_b <= row_b + 3'd1;
  end
  assign row_eq_7_a = (row_a == 3'd7);
  assign row_eq_7_b = (row_b == 3'd7);

  // Observation mux so the same tasks serve either instance.
  logic       sel;
  logic       o_clr, o_renb, o_sclk, o_lat, o_oe_n, o_fd;
  logic [4:0] o_col;
  logic [1:0] o_lp, o_dp;
  logic [2:0] o_row;
  assign o_clr  = sel ? rowct_clr_b  : rowct_clr_a;
  assign o_renb = sel ? rowct_enb_b  : rowct_enb_a;
  assign o_sclk = sel ? sclk_b       : sclk_a;
  assign o_lat  = sel ? lat_b        : lat_a;
  assign o_oe_n = sel ? oe_n_b       : oe_n_a;
  assign o_fd   = sel ? frame_done_b : frame_done_a;
  assign o_col  = sel ? col_b        : col_a;
  assign o_lp   = sel ? load_plane_b : load_plane_a;
  assign o_dp   = sel ? disp_plane_b : disp_plane_a;
  assign o_row  = sel ? row_b        : row_a;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e);
    if (sel) begin
      rst_b = r;
      enb_b = e;
    end else begin
      rst_a = r;
      enb_a = e;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " oe_n"},       int'(o_oe_n), 1);
    checkOutput({tag, " rowct_clr"},  int'(o_clr),  1);
    checkOutput({tag, " rowct_enb"},  int'(o_renb), 0);
    checkOutput({tag, " sclk"},       int'(o_sclk), 0);
    checkOutput({tag, " lat"},        int'(o_lat),  0);
    checkOutput({tag, " frame_done"}, int'(o_fd),   0);
    checkOutput({tag, " col"},        int'(o_col),  0);
    checkOutput({tag, " load_plane"}, int'(o_lp),   0);
    checkOutput({tag, " disp_plane"}, int'(o_dp),   0);
  endtask

  // Expected results for the sub-field closed by latch n (1-based, counted
  // from the enb rising edge). The first sub-field after idle is dark.
  function automatic exp_t expectSub(input int n, input int base);
    exp_t e;
    int   disp;
    disp        = (n == 1) ? 0 : ((n - 2) / 8) % 4;
    e.lit       = (n == 1) ? 0 : (base << disp);
    e.period    = ((e.lit > 64) ? e.lit : 64) + 2;
    e.first_lit = (e.lit != 0) ? 1 : -1;
    e.last_lit  = (e.lit != 0) ? e.lit : -1;
    e.rises     = 32;
    e.last_sclk = 64;
    e.lp        = ((n - 1) / 8) % 4;
    e.dp        = disp;
    e.fd        = (n % 32 == 0) ? 1 : 0;
    e.row       = (n - 1) % 8;
    return e;
  endfunction

  // Called just after sampling a latch (or the idle cycle before SHIFT);
  // runs up to the next latch and compares against the queued record.
  task automatic measureSubfield(input string tag);
    exp_t e;
    int   off, lit, first_lit, last_lit, rises, last_sclk, fd;
    bit   prev_sclk, done;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, observed=0 expected=1 entries", tag);
      return;
    end
    e = sb.pop_front();
    off = 0; lit = 0; first_lit = -1; last_lit = -1; rises = 0; last_sclk = -1; fd = 0;
    prev_sclk = o_sclk;
    done = 1'b0;
    while (!done && off < 1200) begin
      @(negedge clk);
      off++;
      if (!o_oe_n) begin
        lit++;
        if (first_lit < 0) first_lit = off;
        last_lit = off;
      end
      if (o_sclk && !prev_sclk) rises++;
      if (o_sclk) last_sclk = off;
      prev_sclk = o_sclk;
      if (o_fd) fd++;
      if (o_lat) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: observed no lat in %0d cycles, expected period %0d", tag, off, e.period);
      return;
    end
    checkOutput({tag, " period"},     off,        e.period);
    checkOutput({tag, " lit"},        lit,        e.lit);
    checkOutput({tag, " first_lit"},  first_lit,  e.first_lit);
    checkOutput({tag, " last_lit"},   last_lit,   e.last_lit);
    checkOutput({tag, " sclk_rises"}, rises,      e.rises);
    checkOutput({tag, " last_sclk"},  last_sclk,  e.last_sclk);
    checkOutput({tag, " frame_done"}, fd,         e.fd);
    checkOutput({tag, " load_plane"}, int'(o_lp), e.lp);
    checkOutput({tag, " disp_plane"}, int'(o_dp), e.dp);
    checkOutput({tag, " row"},        int'(o_row), e.row);
    checkOutput({tag, " rowct_enb"},  int'(o_renb), 1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat_count, lit_count, clr_at;

    sel   = 1'b0;
    rst_a = 1'b1; enb_a = 1'b0;
    rst_b = 1'b1; enb_b = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset values, BASE_ON=64");
    checkResetValues("reset_a");

    // Start scanning: this negedge is the idle cycle 0.
    $display("[TB] first sub-field, full frame and wrap");
    applyStimulus(1'b0, 1'b1);
    for (int n = 1; n <= 41; n++) sb.push_back(expectSub(n, 64));
    for (int n = 1; n <= 41; n++) measureSubfield($sformatf("a_latch%0d", n));

    // Drop enb mid-SHIFT of a plane-1 sub-field (128 lit cycles).
    $display("[TB] enb dropped mid-shift");
    lat_count = 0; lit_count = 0; clr_at = -1;
    for (int off = 1; off <= 210; off++) begin
      @(negedge clk);
      if (o_lat) lat_count++;
      if (!o_oe_n) lit_count++;
      if (o_clr && clr_at < 0) clr_at = off;
      if (off == 10) applyStimulus(1'b0, 1'b0);
    end
    checkOutput("stop lat_pulses", lat_count, 0);
    checkOutput("stop lit",        lit_count, 128);
    checkOutput("stop idle_at",    clr_at,    130);
    checkOutput("stop rowct_clr",  int'(o_clr),  1);
    checkOutput("stop oe_n",       int'(o_oe_n), 1);
    checkOutput("stop load_plane", int'(o_lp),   0);
    checkOutput("stop disp_plane", int'(o_dp),   0);

    // Restart: row 0, plane 0, dark first sub-field again.
    $display("[TB] restart after stop");
    applyStimulus(1'b0, 1'b1);
    for (int n = 1; n <= 9; n++) sb.push_back(expectSub(n, 64));
    for (int n = 1; n <= 9; n++) measureSubfield($sformatf("restart_latch%0d", n));

    // Plane-1 sub-field: offset 100 is in WAIT with the panel lit.
    $display("[TB] reset during WAIT");
    repeat (100) @(negedge clk);
    checkOutput("wait oe_n", int'(o_oe_n), 0);
    checkOutput("wait sclk", int'(o_sclk), 0);
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkResetValues("midrst");
    applyStimulus(1'b0, 1'b1);
    sb.push_back(expectSub(1, 64));
    measureSubfield("after_rst");

    // Short display time: no WAIT, every sub-field is 66 cycles.
    $display("[TB] BASE_ON=8 instance");
    applyStimulus(1'b1, 1'b0);
    sel = 1'b1;
    @(negedge clk);
    checkResetValues("reset_b");
    applyStimulus(1'b0, 1'b1);
    for (int n = 1; n <= 33; n++) sb.push_back(expectSub(n, 8));
    for (int n = 1; n <= 33; n++) measureSubfield($sformatf("b_latch%0d", n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Scan sequencer for the 32x16 HUB75-style LED matrix (1/8 scan, 3-bit row address).
- Drives the row counter's rowct_clr/rowct_enb and produces the panel strobes sclk, lat and oe_n.
- Supplies column and bit-plane indices to the frame-buffer read path.
- Implements binary-coded modulation: the outer loop is bit-planes, the inner loop is rows. Shifting of the next sub-field overlaps display of the current one.

Parameters:
- COLS, 32, columns shifted per sub-field.
- PLANES, 4, number of bit-planes (colour depth per channel).
- BASE_ON, 64, oe_n-low cycles for plane 0; plane p is lit for BASE_ON<<p cycles.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- enb  input  1  run request; scanning runs while high
- row_eq_7  input  1  from row counter: load row == 7
- rowct_clr  output  1  row counter clear
- rowct_enb  output  1  row counter advance; disp_row <= row, row <= row+1
- col  output  $clog2(COLS)  column index for frame-buffer read
- load_plane  output  $clog2(PLANES)  plane being shifted
- disp_plane  output  $clog2(PLANES)  plane currently displayed
- sclk  output  1  panel shift clock
- lat  output  1  panel latch strobe
- oe_n  output  1  panel output enable, active-low
- frame_done  output  1  one-cycle pulse at the last latch of a frame

Behaviour:
- States:
  - IDLE: waits for enb.
  - SHIFT: shifts column data.
  - WAIT: shift done, display time not yet expired.
  - BLANK: dead time.
  - LATCH: latch strobe and row advance.
- Reset (and every rst cycle):
  - State IDLE; timer 0.
  - col = 0, load_plane = 0, disp_plane = 0.
  - sclk = 0, lat = 0, oe_n = 1, rowct_enb = 0, frame_done = 0, rowct_clr = 1.
  - rst mid-operation aborts immediately; no partial latch is issued.
- IDLE:
  - rowct_clr = 1 and oe_n = 1.
  - enb = 1 -> SHIFT with col = 0 and phase = 0.
- SHIFT:
  - Each column takes 2 cycles: phase 0 has sclk = 0; phase 1 has sclk = 1.
  - col and load_plane are stable across both phases. Panel data is combinational from them.
  - After the phase 1 of col = COLS-1 (2*COLS cycles in total), the FSM moves on:
    - timer == 0 -> BLANK.
    - otherwise -> WAIT.
- WAIT: -> BLANK on the cycle after timer reaches 0.
- BLANK: one cycle with oe_n = 1.
  - enb = 1 -> LATCH.
  - enb = 0 -> IDLE, with load_plane and disp_plane cleared.
- LATCH: one cycle with lat = 1, rowct_enb = 1 and oe_n = 1. On the clock edge:
  - disp_plane <= load_plane.
  - If row_eq_7, load_plane increments, wrapping from PLANES-1 to 0.
  - timer <= BASE_ON << (new disp_plane).
  - State -> SHIFT with col = 0.
- frame_done: pulses in the LATCH cycle when row_eq_7 && load_plane == PLANES-1.
- Display timer:
  - Decrements each cycle while nonzero.
  - oe_n = 0 exactly when timer != 0 and state is SHIFT or WAIT, giving exactly BASE_ON<<p lit cycles.
- Sub-field period = max(2*COLS, BASE_ON<<p) + 2 cycles.
- First sub-field after IDLE: timer = 0, so oe_n stays high until the first LATCH.
- Decode rules: sclk, lat, rowct_enb, rowct_clr and oe_n are pure decodes of registered state, phase and timer, so they are glitch-free relative to clk.
- Widths:
  - Timer width is $clog2((BASE_ON<<(PLANES-1))+1).
  - col wraps only via a state change; it never free-runs.

Decomposition:
- led_pkg holds:
  - scan_state_t enum (IDLE, SHIFT, WAIT, BLANK, LATCH).
  - COLS/PLANES defaults.
  - The function on_time(plane) returning BASE_ON<<plane.
- One sub-module, bcm_on_timer: load/decrement counter with a nonzero flag. The FSM stays in matrix_scan_ctrl.

Test Plan:
1. Reset, then enb = 1 with PLANES = 4, BASE_ON = 64 (row_eq_7 driven by a bench model of the row counter) -> oe_n = 1 and 32 sclk rising edges in cycles 1-64; BLANK at cycle 65; lat = rowct_enb = 1 at cycle 66; oe_n = 0 for exactly 64 cycles starting at cycle 67.
2. Plane 3 sub-field (512 on-cycles) -> SHIFT lasts 64 cycles, then WAIT for 448 cycles, then BLANK and LATCH; period 514 cycles; oe_n low count = 512.
3. Full frame (8 rows × 4 planes) -> 32 lat pulses; load_plane steps 0→1→2→3 at latches where row_eq_7 = 1; exactly one frame_done pulse, at the 32nd latch; load_plane wraps to 0.
4. enb dropped mid-SHIFT -> SHIFT finishes; BLANK goes to IDLE with no lat pulse; rowct_clr = 1, oe_n = 1, both plane indices return to 0; re-assert enb -> scan restarts at row 0, plane 0.
5. rst asserted during WAIT with oe_n = 0 -> the next cycle shows all reset values (oe_n = 1, rowct_clr = 1, timer = 0, state IDLE).
6. BASE_ON = 8 (display shorter than shift) -> no WAIT state; every sub-field period = 66 cycles; oe_n low exactly 8<<p cycles, each lit run starting the cycle after LATCH.
